// File: rtl/uop_cache_sched.sv
// Scheduler and sole owner of the single-port uop_cache BRAM: fill/replay arbitration,
// per-entry valid bits, and an invalidation sweep on reset or clr_req.
module uop_cache_sched #(
  parameter int DEPTH  = 64,
  parameter int IDX_W  = 6,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fill_req,
  input  logic [IDX_W-1:0]  fill_idx,
  input  logic [DATA_W-1:0] fill_data,
  output logic              fill_gnt,
  input  logic              rd_req,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic              rd_hit,
  output logic [DATA_W-1:0] rd_data,
  input  logic              clr_req,
  output logic              busy,
  output logic [15:0]       deny_cnt,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  input  logic [DATA_W-1:0] bram_rdata
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  logic [0:0]       state;
  logic [IDX_W-1:0] sweep_idx;
  logic [DEPTH-1:0] valid;
  logic             rr;
  logic             arb;
  logic             both;

  assign busy    = (state == ST_CLEAR);
  assign rd_data = bram_rdata;

  // Grants are only arbitrated in IDLE with no clear pending; rr=1 favours the fill port.
  always_comb begin
    // NOTE: every output gets a default first so no path through this block infers a latch.
    arb        = (state == ST_IDLE) && !clr_req;
    both       = fill_req && rd_req;
    rd_gnt     = arb && rd_req && (!fill_req || !rr);
    fill_gnt   = arb && fill_req && (!rd_req || rr);
    bram_en    = 1'b0;
    bram_we    = 1'b0;
    bram_addr  = '0;
    bram_wdata = '0;
    if (state == ST_CLEAR) begin
      bram_en   = 1'b1;
      bram_we   = 1'b1;
      bram_addr = ADDR_W'({sweep_idx, 3'b000});
    end else if (fill_gnt) begin
      bram_en    = 1'b1;
      bram_we    = 1'b1;
      bram_addr  = ADDR_W'({fill_idx, 3'b000});
      bram_wdata = fill_data;
    end else if (rd_gnt) begin
      bram_en   = 1'b1;
      bram_addr = ADDR_W'({rd_idx, 3'b000});
    end
  end

  // NOTE: the valid bits are ordinary flops and are reset; the BRAM array itself has no
  // reset, which is why the sweep writes zeros into every entry after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_CLEAR;
      sweep_idx <= '0;
      valid     <= '0;
      rr        <= 1'b0;
      rd_valid  <= 1'b0;
      rd_hit    <= 1'b0;
      deny_cnt  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update reading pre-edge values.
      rd_valid <= rd_gnt;
      rd_hit   <= rd_gnt && valid[rd_idx];
      if (arb && both)
        rr <= !rr;
      if (((fill_req && !fill_gnt) || (rd_req && !rd_gnt)) && (deny_cnt != 16'hFFFF))
        deny_cnt <= deny_cnt + 16'd1;

      case (state)
        ST_CLEAR: begin
          valid[sweep_idx] <= 1'b0;
          if (clr_req) begin
            sweep_idx <= '0;
          end else begin
            sweep_idx <= sweep_idx + 1'b1;
            if (sweep_idx == IDX_W'(DEPTH - 1))
              state <= ST_IDLE;
          end
        end
        default: begin
          if (clr_req) begin
            state     <= ST_CLEAR;
            sweep_idx <= '0;
          end else if (fill_gnt) begin
            valid[fill_idx] <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uop_cache_sched.sv
// Self-checking bench for uop_cache_sched: behavioural BRAM, reference valid/data model,
// and a scoreboard of expected read returns.
module tb_uop_cache_sched;

  localparam int DEPTH  = 64;
  localparam int IDX_W  = 6;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              fill_req, rd_req, clr_req;
  logic [IDX_W-1:0]  fill_idx, rd_idx;
  logic [DATA_W-1:0] fill_data;
  logic              fill_gnt, rd_gnt, rd_valid, rd_hit, busy;
  logic [DATA_W-1:0] rd_data;
  logic [15:0]       deny_cnt;
  logic              bram_en, bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wdata;
  logic [DATA_W-1:0] bram_rdata = '0;

  uop_cache_sched #(.DEPTH(DEPTH), .IDX_W(IDX_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .fill_req(fill_req), .fill_idx(fill_idx), .fill_data(fill_data), .fill_gnt(fill_gnt),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_hit(rd_hit), .rd_data(rd_data),
    .clr_req(clr_req), .busy(busy), .deny_cnt(deny_cnt),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port BRAM; never-written words read back as garbage.
  logic [DATA_W-1:0]       mem [1<<ADDR_W];
  logic [(1<<ADDR_W)-1:0]  written = '0;
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) begin
        mem[bram_addr]     <= bram_wdata;
        written[bram_addr] <= 1'b1;
      end else begin
        bram_rdata <= written[bram_addr] ? mem[bram_addr] : (32'hDEAD_0000 | 32'(bram_addr));
      end
    end
  end

  typedef struct packed {
    logic              hit;
    logic [DATA_W-1:0] data;
  } rd_exp_t;

  rd_exp_t           exp_q[$];
  logic [DEPTH-1:0]  ref_valid = '0;
  logic [DATA_W-1:0] ref_data [DEPTH];
  logic              ref_rr = 1'b0;
  logic [15:0]       ref_deny = '0;
  logic              last_rd_gnt;
  int                total = 0;
  int                bad = 0;

  task automatic clear_model();
    ref_valid = '0;
    for (int i = 0; i < DEPTH; i++) ref_data[i] = '0;
  endtask

  task automatic bump_deny();
    if (ref_deny != 16'hFFFF) ref_deny = ref_deny + 16'd1;
  endtask

  // Scoreboard pop: called at the start of every cycle, at the falling edge.
  task automatic check_return(input string tag);
    rd_exp_t e;
    total++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rd_valid !== 1'b1 || rd_hit !== e.hit || rd_data !== e.data) begin
        bad++;
        $display("FAIL %s rd_return: valid=%b hit=%b data=%h, want valid=1 hit=%b data=%h",
                 tag, rd_valid, rd_hit, rd_data, e.hit, e.data);
      end
    end else if (rd_valid !== 1'b0 || rd_hit !== 1'b0) begin
      bad++;
      $display("FAIL %s rd_idle: valid=%b hit=%b, want valid=0 hit=0", tag, rd_valid, rd_hit);
    end
  endtask

  // One IDLE cycle with the given requests; expected grants come from the arbitration model.
  task automatic arb_cycle(input string tag, input logic f, input logic [IDX_W-1:0] fi,
                           input logic [DATA_W-1:0] fd, input logic r,
                           input logic [IDX_W-1:0] ri);
    logic              exp_r, exp_f;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_wd;
    rd_exp_t           e;
    check_return(tag);
    fill_req = f; fill_idx = fi; fill_data = fd; rd_req = r; rd_idx = ri; clr_req = 1'b0;
    exp_r    = r && (!f || !ref_rr);
    exp_f    = f && (!r || ref_rr);
    exp_addr = exp_f ? {fi, 3'b000} : (exp_r ? {ri, 3'b000} : '0);
    exp_wd   = exp_f ? fd : '0;
    #1;
    total++;
    if (rd_gnt !== exp_r || fill_gnt !== exp_f || bram_en !== (exp_r | exp_f) ||
        bram_we !== exp_f || bram_addr !== exp_addr || bram_wdata !== exp_wd || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s grant: rd_gnt=%b fill_gnt=%b en=%b we=%b addr=%h wdata=%h busy=%b, want %b %b %b %b %h %h 0",
               tag, rd_gnt, fill_gnt, bram_en, bram_we, bram_addr, bram_wdata, busy,
               exp_r, exp_f, exp_r | exp_f, exp_f, exp_addr, exp_wd);
    end
    if (exp_r) begin
      e.hit  = ref_valid[ri];
      e.data = ref_data[ri];
      exp_q.push_back(e);
    end
    if (exp_f) begin
      ref_valid[fi] = 1'b1;
      ref_data[fi]  = fd;
    end
    if (f && r) ref_rr = !ref_rr;
    if ((f && !exp_f) || (r && !exp_r)) bump_deny();
    last_rd_gnt = rd_gnt;
    @(negedge clk);
  endtask

  // 64 sweep cycles starting now, optionally holding fill_req (denied) for the first few.
  task automatic watch_sweep(input string tag, input int hold_fill);
    logic [ADDR_W-1:0] ea;
    for (int k = 0; k < DEPTH; k++) begin
      check_return(tag);
      fill_req = (k < hold_fill); fill_idx = 6'd7; fill_data = 32'h1234_5678;
      rd_req = 1'b0; clr_req = 1'b0;
      ea = ADDR_W'(k << 3);
      #1;
      total++;
      if (busy !== 1'b1 || bram_en !== 1'b1 || bram_we !== 1'b1 || bram_addr !== ea ||
          bram_wdata !== '0 || fill_gnt !== 1'b0 || rd_gnt !== 1'b0) begin
        bad++;
        $display("FAIL %s sweep[%0d]: busy=%b en=%b we=%b addr=%h wdata=%h gnt=%b%b, want 1 1 1 %h 0 00",
                 tag, k, busy, bram_en, bram_we, bram_addr, bram_wdata, fill_gnt, rd_gnt, ea);
      end
      if (k < hold_fill) bump_deny();
      @(negedge clk);
    end
    fill_req = 1'b0;
    clear_model();
    #1;
    total++;
    if (busy !== 1'b0 || bram_en !== 1'b0 || bram_we !== 1'b0 || bram_addr !== '0 || bram_wdata !== '0) begin
      bad++;
      $display("FAIL %s sweep_end: busy=%b en=%b we=%b addr=%h wdata=%h, want all 0",
               tag, busy, bram_en, bram_we, bram_addr, bram_wdata);
    end
    @(negedge clk);
  endtask

  task automatic check_deny(input string tag);
    total++;
    if (deny_cnt !== ref_deny) begin
      bad++;
      $display("FAIL %s deny_cnt: got %0d, want %0d", tag, deny_cnt, ref_deny);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    fill_req = 1'b0; rd_req = 1'b0; clr_req = 1'b0;
    fill_idx = '0; rd_idx = '0; fill_data = '0;
    clear_model();
    #1;
    total++;
    if (busy !== 1'b1 || fill_gnt !== 1'b0 || rd_gnt !== 1'b0 || bram_en !== 1'b1 || bram_we !== 1'b1 ||
        bram_addr !== '0 || bram_wdata !== '0 || rd_valid !== 1'b0 || rd_hit !== 1'b0 || deny_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_state: busy=%b gnt=%b%b en=%b we=%b addr=%h wdata=%h rv=%b hit=%b deny=%0d, want 1 00 1 1 0 0 0 0 0",
               busy, fill_gnt, rd_gnt, bram_en, bram_we, bram_addr, bram_wdata, rd_valid, rd_hit, deny_cnt);
    end
    @(negedge clk);
    reset = 1'b1;
    watch_sweep("reset_sweep", 0);
    check_deny("reset");
  endtask

  task automatic test_fill_read();
    arb_cycle("fill5", 1'b1, 6'd5, 32'h00A0_0093, 1'b0, 6'd0);
    arb_cycle("read5", 1'b0, 6'd0, 32'h0, 1'b1, 6'd5);
    arb_cycle("read6", 1'b0, 6'd0, 32'h0, 1'b1, 6'd6);
    arb_cycle("drain_fr", 1'b0, 6'd0, 32'h0, 1'b0, 6'd0);
    check_deny("fill_read");
  endtask

  task automatic test_back_to_back();
    logic [3:0] seq;
    logic [15:0] deny_before;
    deny_before = ref_deny;
    arb_cycle("both1", 1'b1, 6'd10, 32'hCAFE_0001, 1'b1, 6'd5);  seq[3] = last_rd_gnt;
    arb_cycle("both2", 1'b1, 6'd10, 32'hCAFE_0001, 1'b1, 6'd10); seq[2] = last_rd_gnt;
    arb_cycle("both3", 1'b1, 6'd11, 32'hCAFE_0002, 1'b1, 6'd10); seq[1] = last_rd_gnt;
    arb_cycle("both4", 1'b1, 6'd11, 32'hCAFE_0002, 1'b1, 6'd11); seq[0] = last_rd_gnt;
    arb_cycle("drain_bb", 1'b0, 6'd0, 32'h0, 1'b0, 6'd0);
    total++;
    if (seq !== 4'b1010) begin
      bad++;
      $display("FAIL alternation: rd_gnt sequence=%b, want 1010", seq);
    end
    total++;
    if (deny_cnt !== deny_before + 16'd4) begin
      bad++;
      $display("FAIL deny_plus4: got %0d, want %0d", deny_cnt, deny_before + 16'd4);
    end
  endtask

  task automatic test_clear();
    arb_cycle("fill3", 1'b1, 6'd3, 32'h0030_0113, 1'b0, 6'd0);
    arb_cycle("read3_pre", 1'b0, 6'd0, 32'h0, 1'b1, 6'd3);
    check_return("clr_cycle");
    clr_req = 1'b1; rd_req = 1'b1; rd_idx = 6'd3;
    #1;
    total++;
    if (fill_gnt !== 1'b0 || rd_gnt !== 1'b0 || bram_en !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL clr_cycle_gnt: gnt=%b%b en=%b busy=%b, want 00 0 0", fill_gnt, rd_gnt, bram_en, busy);
    end
    bump_deny();
    @(negedge clk);
    clr_req = 1'b0; rd_req = 1'b0;
    watch_sweep("clr_sweep", 2);
    arb_cycle("read3_post", 1'b0, 6'd0, 32'h0, 1'b1, 6'd3);
    arb_cycle("drain_clr", 1'b0, 6'd0, 32'h0, 1'b0, 6'd0);
    check_deny("clear");
  endtask

  task automatic test_restart();
    check_return("restart_pulse");
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    for (int k = 0; k <= 30; k++) begin
      check_return("restart_pre");
      clr_req = (k == 30);
      #1;
      total++;
      if (busy !== 1'b1 || bram_addr !== ADDR_W'(k << 3)) begin
        bad++;
        $display("FAIL restart_pre[%0d]: busy=%b addr=%h, want 1 %h", k, busy, bram_addr, ADDR_W'(k << 3));
      end
      @(negedge clk);
    end
    clr_req = 1'b0;
    watch_sweep("restart_sweep", 0);
    check_deny("restart");
  endtask

  task automatic test_reset_mid_read();
    arb_cycle("fill5b", 1'b1, 6'd5, 32'hBEEF_0005, 1'b0, 6'd0);
    arb_cycle("rdb1", 1'b0, 6'd0, 32'h0, 1'b1, 6'd5);
    arb_cycle("rdb2", 1'b0, 6'd0, 32'h0, 1'b1, 6'd5);
    arb_cycle("rdb3", 1'b0, 6'd0, 32'h0, 1'b1, 6'd5);
    check_return("rdb_last");
    rd_req = 1'b1; rd_idx = 6'd5;
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (rd_valid !== 1'b0 || rd_hit !== 1'b0 || busy !== 1'b1 || bram_addr !== '0 ||
        rd_gnt !== 1'b0 || deny_cnt !== 16'd0) begin
      bad++;
      $display("FAIL async_reset: rv=%b hit=%b busy=%b addr=%h rd_gnt=%b deny=%0d, want 0 0 1 0 0 0",
               rd_valid, rd_hit, busy, bram_addr, rd_gnt, deny_cnt);
    end
    exp_q.delete();
    ref_rr = 1'b0;
    ref_deny = '0;
    clear_model();
    rd_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    watch_sweep("rst_sweep", 0);
    arb_cycle("read5_post", 1'b0, 6'd0, 32'h0, 1'b1, 6'd5);
    arb_cycle("drain_rst", 1'b0, 6'd0, 32'h0, 1'b0, 6'd0);
    check_deny("reset_mid_read");
  endtask

  initial begin
    test_reset();
    test_fill_read();
    test_back_to_back();
    test_clear();
    test_restart();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
